// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer with registered instruction, branch squash and halt; FETCH_BOOTLOAD_EN adds a boot-load port and BOOT state
module fetch_unit #(
  parameter int                ABITS    = 32,
  parameter int                DBITS    = 32,
  parameter logic [ABITS-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [ABITS-1:0] br_target,
  input  logic             halt_req,
`ifdef FETCH_BOOTLOAD_EN
  input  logic             boot_valid,
  input  logic [DBITS-1:0] boot_data,
  input  logic             boot_done,
`endif
  output logic             imem_en,
  output logic             imem_we,
  output logic [ABITS-1:0] imem_addr,
  output logic [DBITS-1:0] imem_wdata,
  input  logic [DBITS-1:0] imem_rdata,
  output logic [DBITS-1:0] inst,
  output logic [ABITS-1:0] inst_pc,
  output logic             inst_valid,
  output logic             halted
);
`ifdef FETCH_BOOTLOAD_EN
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  localparam state_t RST_STATE = BOOT;
  logic [ABITS-1:0] bptr, bptr_n;
`else
  typedef enum logic [1:0] {RUN, HALT} state_t;
  localparam state_t RST_STATE = RUN;
`endif
  state_t           state, state_n;
  logic [ABITS-1:0] pc, pc_n, inst_pc_n;
  logic [DBITS-1:0] inst_n;
  logic             valid_n;
  assign halted = (state == HALT);
  // register all fetch state; reset wins over every other input
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= RST_STATE;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
`ifdef FETCH_BOOTLOAD_EN
      bptr       <= RESET_PC;
`endif
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
      inst_valid <= valid_n;
`ifdef FETCH_BOOTLOAD_EN
      bptr       <= bptr_n;
`endif
    end
  end
  // next state, datapath updates and memory-port outputs; priority halt > branch > stall > sequential
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    inst_n     = inst;
    inst_pc_n  = inst_pc;
    valid_n    = inst_valid;
    imem_en    = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = pc;
    imem_wdata = '0;
`ifdef FETCH_BOOTLOAD_EN
    bptr_n     = bptr;
`endif
    case (state)
      RUN: begin
        imem_en = 1'b1;
        if (halt_req) begin
          state_n = HALT;
          valid_n = 1'b0;
        end else if (br_taken) begin
          pc_n      = br_target;
          inst_n    = imem_rdata;
          inst_pc_n = pc;
          valid_n   = 1'b0;
        end else if (!stall) begin
          pc_n      = pc + ABITS'(1);
          inst_n    = imem_rdata;
          inst_pc_n = pc;
          valid_n   = 1'b1;
        end
      end
      HALT: valid_n = 1'b0;
`ifdef FETCH_BOOTLOAD_EN
      BOOT: begin
        imem_en    = 1'b1;
        imem_we    = boot_valid;
        imem_addr  = bptr;
        imem_wdata = boot_data;
        valid_n    = 1'b0;
        bptr_n     = bptr + ABITS'(boot_valid);
        if (boot_done) begin
          state_n = RUN;
          pc_n    = RESET_PC;
        end
      end
`endif
      default: state_n = RUN;
    endcase
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch sequencing, stall, branch squash, halt, PC wrap and (with FETCH_BOOTLOAD_EN) boot loading
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_n, stall, br_taken, halt_req;
  logic [31:0] br_target;
  logic        imem_en, imem_we, inst_valid, halted;
  logic [31:0] imem_addr, imem_wdata, imem_rdata, inst, inst_pc;
  logic        boot_valid, boot_done;
  logic [31:0] boot_data;
  logic        en4, we4, valid4, halted4;
  logic [3:0]  addr4, pc4;
  logic [7:0]  wdata4, rdata4, inst4;
  logic [63:0] wv = '0;
  logic [31:0] wm [64];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .halt_req(halt_req),
`ifdef FETCH_BOOTLOAD_EN
    .boot_valid(boot_valid), .boot_data(boot_data), .boot_done(boot_done),
`endif
    .imem_en(imem_en), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_rdata(imem_rdata), .inst(inst),
    .inst_pc(inst_pc), .inst_valid(inst_valid), .halted(halted)
  );
  fetch_unit #(.ABITS(4), .DBITS(8), .RESET_PC(4'hF)) u4 (
    .clk(clk), .reset_n(reset_n), .stall(1'b0), .br_taken(1'b0),
    .br_target(4'h0), .halt_req(1'b0),
`ifdef FETCH_BOOTLOAD_EN
    .boot_valid(1'b0), .boot_data(8'h00), .boot_done(boot_done),
`endif
    .imem_en(en4), .imem_we(we4), .imem_addr(addr4),
    .imem_wdata(wdata4), .imem_rdata(rdata4), .inst(inst4),
    .inst_pc(pc4), .inst_valid(valid4), .halted(halted4)
  );
  assign rdata4 = {4'h5, addr4};
  assign imem_rdata = wv[imem_addr[5:0]] ? wm[imem_addr[5:0]] :
                      (imem_addr < 32'd4) ? 32'hA0 + imem_addr : 32'hB000_0000 + imem_addr;
  always @(posedge clk)
    if (imem_we) begin
      wv[imem_addr[5:0]] <= 1'b1;
      wm[imem_addr[5:0]] <= imem_wdata;
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  initial begin
    reset_n = 1'b0; stall = 1'b0; br_taken = 1'b0; halt_req = 1'b0; br_target = '0;
    boot_valid = 1'b0; boot_data = '0; boot_done = 1'b0;
    #1;
    tick();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_en", 32'(imem_en), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    reset_n = 1'b1;
`ifdef FETCH_BOOTLOAD_EN
    boot_done = 1'b1;
    tick();
    boot_done = 1'b0;
`endif
    chk("w4_addr_f", 32'(addr4), 32'hF);
    chk("run_addr0", imem_addr, 32'd0);
    tick();
    chk("seq0_inst", inst, 32'hA0);
    chk("seq0_pc", inst_pc, 32'd0);
    chk("seq0_valid", 32'(inst_valid), 32'd1);
    chk("w4_addr_wrap", 32'(addr4), 32'h0);
    chk("w4_inst", 32'(inst4), 32'h5F);
    chk("w4_inst_pc", 32'(pc4), 32'hF);
    tick();
    chk("seq1_inst", inst, 32'hA1);
    chk("seq1_pc", inst_pc, 32'd1);
    chk("seq1_addr", imem_addr, 32'd2);
    stall = 1'b1;
    tick();
    tick();
    chk("stall_addr", imem_addr, 32'd2);
    chk("stall_inst", inst, 32'hA1);
    chk("stall_pc", inst_pc, 32'd1);
    chk("stall_valid", 32'(inst_valid), 32'd1);
    stall = 1'b0;
    tick();
    chk("resume_inst", inst, 32'hA2);
    chk("resume_pc", inst_pc, 32'd2);
    chk("resume_addr", imem_addr, 32'd3);
    br_taken = 1'b1; br_target = 32'h10;
    tick();
    br_taken = 1'b0;
    chk("br_valid", 32'(inst_valid), 32'd0);
    chk("br_addr", imem_addr, 32'h10);
    tick();
    chk("br_inst", inst, 32'hB000_0010);
    chk("br_inst_pc", inst_pc, 32'h10);
    chk("br_valid2", 32'(inst_valid), 32'd1);
    br_taken = 1'b1; stall = 1'b1; br_target = 32'h3;
    tick();
    br_taken = 1'b0; stall = 1'b0;
    chk("br_over_stall_addr", imem_addr, 32'h3);
    chk("br_over_stall_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("br2_inst", inst, 32'hA3);
    chk("br2_inst_pc", inst_pc, 32'h3);
    halt_req = 1'b1; br_taken = 1'b1; stall = 1'b1; br_target = 32'h20;
    tick();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_en", 32'(imem_en), 32'd0);
    chk("halt_we", 32'(imem_we), 32'd0);
    chk("halt_valid", 32'(inst_valid), 32'd0);
    chk("halt_inst", inst, 32'hA3);
    chk("halt_inst_pc", inst_pc, 32'h3);
    halt_req = 1'b0; stall = 1'b0;
    tick();
    tick();
    br_taken = 1'b0;
    chk("halt_stay", 32'(halted), 32'd1);
    chk("halt_hold_inst", inst, 32'hA3);
    chk("halt_hold_valid", 32'(inst_valid), 32'd0);
    chk("w4_not_halted", 32'(halted4), 32'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_addr", imem_addr, 32'd0);
    chk("rst2_inst", inst, 32'd0);
    chk("rst2_valid", 32'(inst_valid), 32'd0);
`ifdef FETCH_BOOTLOAD_EN
    chk("boot_addr0", imem_addr, 32'd0);
    boot_valid = 1'b1; boot_data = 32'h11;
    #1;
    chk("boot_we", 32'(imem_we), 32'd1);
    chk("boot_wdata", imem_wdata, 32'h11);
    tick();
    boot_data = 32'h22;
    #1;
    chk("boot_addr1", imem_addr, 32'd1);
    tick();
    boot_data = 32'h33; boot_done = 1'b1;
    #1;
    chk("boot_addr2", imem_addr, 32'd2);
    tick();
    boot_valid = 1'b0; boot_done = 1'b0;
    chk("boot_run_addr", imem_addr, 32'd0);
    chk("boot_mem2", imem_rdata == 32'h11 ? wm[2] : 32'hDEAD, 32'h33);
    tick();
    chk("boot_inst0", inst, 32'h11);
    chk("boot_valid0", 32'(inst_valid), 32'd1);
    tick();
    chk("boot_inst1", inst, 32'h22);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; boot_valid = 1'b1; boot_data = 32'h44;
    tick();
    tick();
    chk("midboot_ptr", imem_addr, 32'd2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; boot_valid = 1'b0;
    #1;
    chk("midboot_rst_ptr", imem_addr, 32'd0);
    chk("midboot_we", 32'(imem_we), 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
